// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester arbiter and sequencer for one shared ALU
//
// Purpose:
//   Grants one of two requesters, latches its opcode and operands, and drives
//   them onto the shared ALU for one evaluation cycle. It then captures the
//   result and flags and returns them on the granted requester's response
//   channel. Illegal opcodes (0 or above MAX_OPC) skip the ALU. They are
//   answered with rsp_err=1 and zero result and flags.
//
// Configuration:
//   ALU_ARB_RR_EN defined   : round-robin on contention (first contention -> 0)
//   ALU_ARB_RR_EN undefined : fixed priority, requester 0 wins contention
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]   request handshake, bit i = requester i
//   req_opcode/req_a/req_b      packed per-requester payload
//   rsp_valid/rsp_ready [1:0]   response handshake, bit i = requester i
//   rsp_result/rsp_flags/rsp_err shared response payload, flags {c,v,n,z}
//   alu_opcode/alu_a/alu_b      drive to the shared ALU (NOOP outside EXEC)
//   alu_result/alu_carry/alu_ovf/alu_neg/alu_zero  ALU outputs

module alu_share_arb #(
  parameter int                DATA_W  = 32,
  parameter int                OPC_W   = 5,
  parameter logic [OPC_W-1:0]  MAX_OPC = 5'b10100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*OPC_W-1:0]    req_opcode,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic [OPC_W-1:0]      alu_opcode,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_ovf,
  input  logic                  alu_neg,
  input  logic                  alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [3:0]          flags_q, flags_d;
  logic                err_q, err_d;

  logic                grant_sel;
  logic                accept;
  logic [OPC_W-1:0]    sel_opc;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                sel_legal;

  // With no request pending, grant_sel just repeats last_grant_q. It is
  // never used in that case because nothing is accepted.
  always_comb begin
    grant_sel = last_grant_q;
    case (req_valid)
      2'b01: grant_sel = 1'b0;
      2'b10: grant_sel = 1'b1;
`ifdef ALU_ARB_RR_EN
      2'b11: grant_sel = ~last_grant_q;
`else
      2'b11: grant_sel = 1'b0;
`endif
      default: grant_sel = last_grant_q;
    endcase
  end

  assign accept    = (state_q == IDLE) && (|req_valid);
  assign sel_opc   = grant_sel ? req_opcode[OPC_W +: OPC_W] : req_opcode[0 +: OPC_W];
  assign sel_a     = grant_sel ? req_a[DATA_W +: DATA_W]    : req_a[0 +: DATA_W];
  assign sel_b     = grant_sel ? req_b[DATA_W +: DATA_W]    : req_b[0 +: DATA_W];
  assign sel_legal = (sel_opc != '0) && (sel_opc <= MAX_OPC);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    opc_d        = opc_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    flags_d      = flags_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d        = grant_sel;
          last_grant_d = grant_sel;
          opc_d        = sel_opc;
          a_d          = sel_a;
          b_d          = sel_b;
          if (sel_legal) begin
            state_d = EXEC;
          end else begin
            // Rejected without touching the ALU.
            res_d   = '0;
            flags_d = 4'b0000;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        res_d   = alu_result;
        flags_d = {alu_carry, alu_ovf, alu_neg, alu_zero};
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        // Only the granted requester's ready can complete the response.
        if (rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      opc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      flags_q      <= 4'b0000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      opc_q        <= opc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = accept ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid  = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

  // Operands stay on the ALU inputs between ops. The opcode is NOOP outside EXEC.
  assign alu_opcode = (state_q == EXEC) ? opc_q : '0;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb

module tb_alu_share_arb;

  localparam int DATA_W = 32;
  localparam int OPC_W  = 5;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*OPC_W-1:0]  req_opcode;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_result;
  logic [3:0]          rsp_flags;
  logic                rsp_err;
  logic [OPC_W-1:0]    alu_opcode;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry, alu_ovf, alu_neg, alu_zero;

  int n_vec = 0;
  int n_err = 0;

  alu_share_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .alu_neg    (alu_neg),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  // Reference ALU: ADD, SUB (carry = no borrow), OR; other opcodes give 0.
  logic [DATA_W:0] wide;
  always_comb begin
    wide      = '0;
    alu_ovf   = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        wide    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_ovf = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
      end
      OP_SUB: begin
        wide    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_ovf = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
      end
      OP_OR:   wide = {1'b0, alu_a | alu_b};
      default: wide = '0;
    endcase
    alu_result = wide[DATA_W-1:0];
    alu_carry  = wide[DATA_W];
    alu_neg    = wide[DATA_W-1];
    alu_zero   = (wide[DATA_W-1:0] == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0]  exp_g;
  logic [4:0]  bad_opc [2];

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 2'b00;
    bad_opc[0] = 5'b10101;
    bad_opc[1] = 5'b00000;
    @(negedge clk);
    step();

    // Reset values
    check("rst_rsp_valid",  rsp_valid,  2'b00);
    check("rst_req_ready",  req_ready,  2'b00);
    check("rst_alu_opcode", alu_opcode, 5'd0);
    check("rst_alu_a",      alu_a,      32'd0);
    check("rst_result",     rsp_result, 32'd0);
    check("rst_flags_err",  {rsp_flags, rsp_err}, 5'b0);
    rst_n = 1'b1;
    step();

    // Single ADD from requester 0, overflow into sign bit
    rsp_ready  = 2'b11;
    req_valid  = 2'b01;
    req_opcode = {5'd0, OP_ADD};
    req_a      = {32'd0, 32'h7FFF_FFFF};
    req_b      = {32'd0, 32'h0000_0001};
    #1 check("add_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    check("add_exec_opc",   alu_opcode, OP_ADD);
    check("add_exec_a",     alu_a,      32'h7FFF_FFFF);
    check("add_exec_nrsp",  rsp_valid,  2'b00);
    step();
    check("add_rsp_valid",  rsp_valid,  2'b01);
    check("add_result",     rsp_result, 32'h8000_0000);
    check("add_flags",      rsp_flags,  4'b0110);
    check("add_err",        rsp_err,    1'b0);
    check("add_resp_noop",  alu_opcode, 5'd0);
    step();
    check("add_done",       rsp_valid,  2'b00);

    // Illegal opcode from requester 1
    req_valid  = 2'b10;
    req_opcode = {5'b11111, 5'd0};
    #1 check("ill_req_ready", req_ready, 2'b10);
    check("ill_acc_noop", alu_opcode, 5'd0);
    step();
    req_valid = 2'b00;
    check("ill_rsp_valid",  rsp_valid,  2'b10);
    check("ill_result",     rsp_result, 32'd0);
    check("ill_flags",      rsp_flags,  4'b0000);
    check("ill_err",        rsp_err,    1'b1);
    check("ill_noop",       alu_opcode, 5'd0);
    step();
    check("ill_done",       rsp_valid,  2'b00);

    // MAX_OPC is legal and goes through EXEC
    req_valid  = 2'b01;
    req_opcode = {5'd0, 5'b10100};
    step();
    req_valid = 2'b00;
    check("max_exec_opc",  alu_opcode, 5'b10100);
    check("max_exec_nrsp", rsp_valid,  2'b00);
    step();
    check("max_rsp_valid", rsp_valid,  2'b01);
    check("max_err",       rsp_err,    1'b0);
    step();

    // Just above MAX_OPC and opcode 0 are rejected
    for (int i = 0; i < 2; i++) begin
      req_valid  = 2'b01;
      req_opcode = {5'd0, bad_opc[i]};
      step();
      req_valid = 2'b00;
      check($sformatf("bad%0d_rsp_valid", i), rsp_valid,  2'b01);
      check($sformatf("bad%0d_err", i),       rsp_err,    1'b1);
      check($sformatf("bad%0d_noop", i),      alu_opcode, 5'd0);
      step();
    end

    // Contention after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    req_valid  = 2'b11;
    req_opcode = {OP_OR, OP_SUB};
    req_a      = {32'h0000_00F0, 32'd5};
    req_b      = {32'h0000_000F, 32'd5};
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1 check($sformatf("cont%0d_grant", k), req_ready, exp_g);
      step();
      step();
      check($sformatf("cont%0d_rsp_valid", k), rsp_valid, exp_g);
      check($sformatf("cont%0d_result", k), rsp_result,
            (exp_g == 2'b01) ? 32'd0 : 32'h0000_00FF);
      check($sformatf("cont%0d_flags", k), rsp_flags,
            (exp_g == 2'b01) ? 4'b1001 : 4'b0000);
      step();
    end

    // Backpressure: requester 0 (next grant in both builds) stalls in RESP
    rsp_ready = 2'b00;
    #1 check("bp_grant", req_ready, 2'b01);
    step();
    step();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_rsp_valid", i), rsp_valid,  2'b01);
      check($sformatf("bp%0d_req_ready", i), req_ready,  2'b00);
      check($sformatf("bp%0d_result", i),    rsp_result, 32'd0);
      check($sformatf("bp%0d_flags", i),     rsp_flags,  4'b1001);
      step();
    end
    rsp_ready = 2'b11;
    step();
`ifdef ALU_ARB_RR_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    check("bp_next_accept", req_ready, exp_g);
    step();

    // Reset during EXEC aborts the in-flight op
    req_valid = 2'b00;
    check("abort_exec_opc", alu_opcode, (exp_g == 2'b10) ? OP_OR : OP_SUB);
    rst_n = 1'b0;
    #1;
    check("abort_alu_opcode", alu_opcode, 5'd0);
    check("abort_alu_ab",     {alu_a, alu_b}, 64'd0);
    check("abort_rsp_valid",  rsp_valid,  2'b00);
    check("abort_flags_err",  {rsp_flags, rsp_err}, 5'b0);
    check("abort_result",     rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("abort%0d_no_rsp", i), rsp_valid, 2'b00);
    end

    // Normal operation after the abort
    req_valid  = 2'b01;
    req_opcode = {5'd0, OP_ADD};
    req_a      = {32'd0, 32'd2};
    req_b      = {32'd0, 32'd3};
    #1 check("post_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    check("post_rsp_valid", rsp_valid,  2'b01);
    check("post_result",    rsp_result, 32'd5);
    check("post_flags",     rsp_flags,  4'b0000);
    step();
    check("post_done",      rsp_valid,  2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbitrates and sequences a single shared ALU instance between two requesters in the execution stage. Typical requesters are the main EX pipe and an auxiliary address-generation or test port. Each accepted request is latched, driven onto the ALU for one evaluation cycle, captured with its flags and returned over a per-requester valid/ready response channel. Opcodes the ALU does not decode are rejected without occupying the ALU.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OPC_W, 5, opcode width.
- MAX_OPC, 5'b10100, highest legal opcode (SB); legal range is 5'b00001..MAX_OPC.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle, one-hot or zero.
- req_opcode  in  2*OPC_W  opcode, requester i at [OPC_W*i +: OPC_W].
- req_a  in  2*DATA_W  operand A, packed as above.
- req_b  in  2*DATA_W  operand B, packed as above.
- rsp_valid  out  2  response valid for requester i, one-hot or zero.
- rsp_ready  in  2  response consumed.
- rsp_result  out  DATA_W  captured ALU result.
- rsp_flags  out  4  {carryOut, overflow, negative, zero}.
- rsp_err  out  1  illegal opcode; result and flags are zero.
- alu_opcode  out  OPC_W  to ALU.
- alu_a  out  DATA_W  to ALU BussA.
- alu_b  out  DATA_W  to ALU BussB.
- alu_result  in  DATA_W  from ALU.
- alu_carry, alu_ovf, alu_neg, alu_zero  in  1 each  ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant computed combinationally from req_valid. req_ready[g] = 1 for the granted requester only.
  - On accept, latch opcode, A, B and grant index g.
  - Legal opcode goes to EXEC.
  - Illegal opcode (0 or >MAX_OPC) goes to RESP with result=0, flags=0, rsp_err=1.
- EXEC: alu_opcode/alu_a/alu_b are driven from the latched values. At the end of the cycle, capture alu_result and the flags, clear rsp_err, then go to RESP.
- RESP: rsp_valid[g]=1. Result, flags and err are held stable until rsp_ready[g]=1. On that handshake, return to IDLE.
  - rsp_ready[~g] is ignored.
- Outside EXEC: alu_opcode=5'b00000 (NOOP). alu_a and alu_b hold the last latched value.
- No request is accepted while in EXEC or RESP; req_ready=2'b00.
- Requesters must hold valid and payload stable until ready. Dropping valid earlier is legal and simply withdraws the request.
- last_grant register updates on every accept.

## Timing
- Reset values:
  - state=IDLE, last_grant=1.
  - Latched opcode/A/B=0, rsp_result=0, rsp_flags=0, rsp_err=0.
  - rsp_valid=0, alu_opcode=0, alu_a=0, alu_b=0.
  - req_ready is 0 until the first valid.
- Legal op: accept at cycle N, EXEC at N+1, rsp_valid at N+2.
- Illegal op: accept at cycle N, rsp_valid at N+1.
- Back-to-back: a response handshake at cycle M returns the FSM to IDLE at M+1, so the next accept happens no earlier than M+1. Minimum spacing is 3 cycles for legal ops and 2 for illegal ops.
- Response backpressure is unbounded; the FSM stays in RESP.
- Reset asserted mid-operation aborts immediately. No response is issued for the in-flight request.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration. When both requesters are valid, grant goes to ~last_grant. The first contention after reset goes to requester 0.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention. last_grant is still maintained but is not used.

## Test plan
- Single ADD from requester 0: A=32'h7FFFFFFF, B=1, opcode 5'b00001, rsp_ready=1. Expect rsp_valid=2'b01 two cycles after accept, result 32'h80000000, flags {carry=0, ovf=1, neg=1, zero=0}, err=0.
- Illegal opcode 5'b11111 from requester 1. Expect rsp_valid=2'b10 one cycle after accept, result 0, flags 0, err=1, and alu_opcode stays 0 throughout.
- Both requesters valid continuously, with SUB 5 - 5 on requester 0 and OR 0xF0|0x0F on requester 1.
  - With ALU_ARB_RR_EN: grants alternate 0, 1, 0, 1, with results 0 (zero=1) and 0xFF.
  - Without it: requester 0 is always granted.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_result and rsp_flags must stay stable, and req_ready must stay 2'b00 even with req_valid=2'b11. Release rsp_ready, then expect the next accept in the following cycle.
- Assert rst_n=0 during EXEC. Outputs must return to their reset values asynchronously, and no rsp_valid may appear afterwards. A new request after reset must be accepted normally.
